// File: rtl/x_500_mod_997_stream_loader_pkg.sv
// Shared constants, state encoding and the chunk-weight helper for the
// mod-997 stream loader and its combinational reducer.
package x_500_mod_997_stream_loader_pkg;

  localparam int unsigned MOD_997 = 32'd997;
  localparam int unsigned X_WIDTH = 32'd500;
  localparam int unsigned R_WIDTH = 32'd10;
  // The reducer splits X into R_WIDTH-bit chunks; 2^10 mod 997 = 27 is the fold factor.
  localparam int unsigned CHUNKS  = X_WIDTH / R_WIDTH;
  localparam int unsigned FOLD    = 32'd27;

  typedef enum logic [0:0] {
    LOAD = 1'b0,
    EVAL = 1'b1
  } state_t;

  // Weight of chunk idx: 2^(10*idx) mod 997, i.e. 27^idx mod 997.
  function automatic logic [R_WIDTH-1:0] chunk_weight(input int unsigned idx);
    int unsigned w;
    w = 32'd1;
    for (int unsigned j = 32'd0; j < idx; j++) begin
      w = (w * FOLD) % MOD_997;
    end
    return w[R_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/x_500_mod_997_stream_loader_x_500_mod_997.sv
// Combinational 500-bit mod-997 reducer. Each 10-bit chunk is scaled by its
// constant weight, the products are summed, and the sum is folded down using
// 2^10 == 27 (mod 997) until a single conditional subtract finishes the job.
module x_500_mod_997
  import x_500_mod_997_stream_loader_pkg::*;
(
  input  logic [X_WIDTH-1:0] x,
  output logic [R_WIDTH-1:0] r
);

  logic [19:0] prod_s [CHUNKS];
  logic [25:0] sum_s;   // 50 * 1023 * 996 < 2^26
  logic [20:0] f1_s;    // <= 1023 + 65535*27
  logic [15:0] f2_s;    // <= 1023 + 2047*27
  logic [11:0] f3_s;    // <= 1023 + 63*27
  logic [10:0] f4_s;    // <= 1023 + 3*27 = 1104

  for (genvar g = 0; g < CHUNKS; g++) begin : g_chunk
    localparam logic [R_WIDTH-1:0] W = chunk_weight(g);
    assign prod_s[g] = {10'd0, x[g*R_WIDTH +: R_WIDTH]} * {10'd0, W};
  end

  // Sum the weighted chunks, fold the sum below 2*997, then subtract once.
  always_comb begin
    sum_s = 26'd0;
    for (int unsigned i = 32'd0; i < CHUNKS; i++) begin
      sum_s = sum_s + {6'd0, prod_s[i]};
    end
    f1_s = {11'd0, sum_s[9:0]} + {5'd0, sum_s[25:10]} * 21'd27;
    f2_s = {6'd0, f1_s[9:0]}   + {5'd0, f1_s[20:10]}  * 16'd27;
    f3_s = {2'd0, f2_s[9:0]}   + {6'd0, f2_s[15:10]}  * 12'd27;
    f4_s = {1'd0, f3_s[9:0]}   + {9'd0, f3_s[11:10]}  * 11'd27;
    // f4 < 2*997, so one subtract suffices; the low 10 bits of f4-997 are exact.
    if (f4_s >= 11'd997) begin
      r = f4_s[9:0] - 10'd997;
    end else begin
      r = f4_s[9:0];
    end
  end

endmodule

// File: rtl/x_500_mod_997_stream_loader.sv
// Streaming front end for the mod-997 reducer: gathers an operand from
// LSB-first beats, lets the reducer settle for one cycle, and hands the
// registered residue out on a valid/ready port that can absorb one result
// while the next operand is loading.
module x_500_mod_997_stream_loader
  import x_500_mod_997_stream_loader_pkg::*;
#(
  parameter int unsigned IN_W = 32'd50
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [IN_W-1:0]    in_data,
  input  logic               in_valid,
  input  logic               in_last,
  output logic               in_ready,
  output logic [R_WIDTH-1:0] res_data,
  output logic               res_valid,
  input  logic               res_ready,
  output logic               err_len
);

  localparam int unsigned BEATS = X_WIDTH / IN_W;
  localparam int unsigned CNT_W = (BEATS > 32'd1) ? $clog2(BEATS) : 32'd1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BEATS - 32'd1);

  if ((X_WIDTH % IN_W) != 32'd0) begin : g_bad_in_w
    $error("IN_W must divide X_WIDTH evenly");
  end

  state_t               state_r, state_s;
  logic [CNT_W-1:0]     beat_cnt_r, beat_cnt_s;
  logic [X_WIDTH-1:0]   x_r, x_s;
  logic [R_WIDTH-1:0]   res_data_r, res_data_s;
  logic                 res_valid_r, res_valid_s;
  logic                 err_len_r, err_len_s;
  logic [R_WIDTH-1:0]   r_s;

  x_500_mod_997 u_reducer (
    .x (x_r),
    .r (r_s)
  );

  // Next-state logic: beat assembly in LOAD, result capture in EVAL, output drain.
  always_comb begin
    state_s     = state_r;
    beat_cnt_s  = beat_cnt_r;
    x_s         = x_r;
    res_data_s  = res_data_r;
    err_len_s   = err_len_r;
    // A consumed result drops valid unless EVAL captures a new one below.
    if (res_valid_r && res_ready) begin
      res_valid_s = 1'b0;
    end else begin
      res_valid_s = res_valid_r;
    end
    case (state_r)
      LOAD: begin
        if (in_valid) begin
          if (beat_cnt_r == {CNT_W{1'b0}}) begin
            // First beat wipes the previous operand so short frames zero-extend.
            x_s = {X_WIDTH{1'b0}};
            x_s[IN_W-1:0] = in_data;
          end else begin
            x_s[32'(beat_cnt_r) * IN_W +: IN_W] = in_data;
          end
          if (in_last || (beat_cnt_r == LAST_IDX)) begin
            state_s    = EVAL;
            beat_cnt_s = {CNT_W{1'b0}};
            if (!in_last) begin
              err_len_s = 1'b1;
            end else begin
              err_len_s = err_len_r;
            end
          end else begin
            beat_cnt_s = beat_cnt_r + CNT_W'(1);
          end
        end else begin
          state_s = LOAD;
        end
      end
      EVAL: begin
        if (!res_valid_r || res_ready) begin
          res_data_s  = r_s;
          res_valid_s = 1'b1;
          state_s     = LOAD;
        end else begin
          state_s = EVAL;
        end
      end
      default: begin
        state_s    = LOAD;
        beat_cnt_s = {CNT_W{1'b0}};
      end
    endcase
  end

  // State and datapath registers; reset discards any partial operand and pending result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= LOAD;
      beat_cnt_r  <= {CNT_W{1'b0}};
      x_r         <= {X_WIDTH{1'b0}};
      res_data_r  <= {R_WIDTH{1'b0}};
      res_valid_r <= 1'b0;
      err_len_r   <= 1'b0;
    end else begin
      state_r     <= state_s;
      beat_cnt_r  <= beat_cnt_s;
      x_r         <= x_s;
      res_data_r  <= res_data_s;
      res_valid_r <= res_valid_s;
      err_len_r   <= err_len_s;
    end
  end

  assign in_ready  = (state_r == LOAD);
  assign res_data  = res_data_r;
  assign res_valid = res_valid_r;
  assign err_len   = err_len_r;

endmodule
